// File: rtl/adc_conversion_scheduler_if.sv
// Request/response and SPI-engine bundle for adc_conversion_scheduler.
// master: requesters + engine side; slave: the scheduler itself.
interface adc_conversion_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 12
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_channel;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [DATA_W-1:0]  rsp_data;
  logic               rsp_error;
  logic               conv_start;
  logic               conv_channel;
  logic               conv_busy;
  logic               conv_done;
  logic [DATA_W-1:0]  conv_data;
  logic               sched_busy;

  modport master (
    output req_valid, req_channel,
    output conv_busy, conv_done, conv_data,
    input  req_ready, rsp_valid,
    input  rsp_data, rsp_error,
    input  conv_start, conv_channel,
    input  sched_busy
  );

  modport slave (
    input  req_valid, req_channel,
    input  conv_busy, conv_done, conv_data,
    output req_ready, rsp_valid,
    output rsp_data, rsp_error,
    output conv_start, conv_channel,
    output sched_busy
  );
endinterface

// File: rtl/adc_conversion_scheduler.sv
// Round-robin scheduler sharing one MCP3202 SPI conversion engine.
// Ports: sys_clk, sys_reset (sync, active-high), bus (slave modport).
// Optional ADC_AVG_EN: 4 conversions per request, response = sum>>2.
module adc_conversion_scheduler #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_W         = 12,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input logic sys_clk,
  input logic sys_reset,
  adc_conversion_scheduler_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     ptr, ptr_nxt;
  logic [IW-1:0]     id, id_nxt;
  logic [IW-1:0]     win;
  logic              win_ok;
  logic              chan, chan_nxt;
  logic [CW-1:0]     cnt, cnt_nxt, cnt_inc;
  logic              tmo;
  logic [DATA_W-1:0] data, data_nxt;
  logic              err, err_nxt;
`ifdef ADC_AVG_EN
  logic [1:0]        nconv, nconv_nxt;
  logic [DATA_W+1:0] acc, acc_nxt, sum;
`endif

  // First valid requester after the last winner, wrapping.
  always_comb begin : arb
    int j;
    logic [IW-1:0] jj;
    j = 0;
    jj = '0;
    win = '0;
    win_ok = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      jj = IW'(j);
      if (!win_ok && bus.req_valid[jj]) begin
        win = jj;
        win_ok = 1'b1;
      end
    end
  end

  // The counter is cleared on the start pulse, so the value it is
  // stepping to equals the number of cycles elapsed since start.
  assign cnt_inc = cnt + CW'(1);
  assign tmo = (cnt_inc == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin : fsm
    state_nxt = state;
    ptr_nxt = ptr;
    id_nxt = id;
    chan_nxt = chan;
    cnt_nxt = cnt;
    data_nxt = data;
    err_nxt = err;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.conv_start = 1'b0;
`ifdef ADC_AVG_EN
    nconv_nxt = nconv;
    acc_nxt = acc;
    sum = acc + {2'b00, bus.conv_data};
`endif
    unique case (state)
      IDLE: begin
        if (win_ok) begin
          bus.req_ready[win] = 1'b1;
          id_nxt = win;
          ptr_nxt = win;
          chan_nxt = bus.req_channel[win];
          state_nxt = LAUNCH;
`ifdef ADC_AVG_EN
          nconv_nxt = '0;
          acc_nxt = '0;
`endif
        end
      end
      LAUNCH: begin
        if (!bus.conv_busy) begin
          bus.conv_start = 1'b1;
          cnt_nxt = '0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt_inc;
        if (bus.conv_done) begin
`ifdef ADC_AVG_EN
          if (nconv == 2'd3) begin
            data_nxt = sum[DATA_W+1:2];
            err_nxt = 1'b0;
            state_nxt = RESP;
          end else begin
            acc_nxt = sum;
            nconv_nxt = nconv + 2'd1;
            state_nxt = LAUNCH;
          end
`else
          data_nxt = bus.conv_data;
          err_nxt = 1'b0;
          state_nxt = RESP;
`endif
        end else if (tmo) begin
          data_nxt = '0;
          err_nxt = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid[id] = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state <= IDLE;
      ptr <= IW'(NUM_REQ - 1);
      id <= '0;
      chan <= 1'b0;
      cnt <= '0;
      data <= '0;
      err <= 1'b0;
`ifdef ADC_AVG_EN
      nconv <= '0;
      acc <= '0;
`endif
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
      id <= id_nxt;
      chan <= chan_nxt;
      cnt <= cnt_nxt;
      data <= data_nxt;
      err <= err_nxt;
`ifdef ADC_AVG_EN
      nconv <= nconv_nxt;
      acc <= acc_nxt;
`endif
    end
  end

  assign bus.rsp_data = data;
  assign bus.rsp_error = err;
  assign bus.conv_channel = chan;
  assign bus.sched_busy = (state != IDLE);
endmodule

// File: doc/adc_conversion_scheduler.md
Name: adc_conversion_scheduler

Overview:
- Shares one start-triggered MCP3202 SPI conversion engine between NUM_REQ requesters, such as the P-control loop and telemetry.
- Each requester asks for a single-ended conversion on channel 0 or 1. The block arbitrates round-robin, launches one conversion at a time and routes the 12-bit result back to the winning requester.
- A watchdog converts a hung conversion into an error response.
- Sits between the control logic and the SPI ADC engine.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- DATA_W, 12, conversion result width.
- TIMEOUT_CYCLES, 2048, maximum sys_clk cycles in WAIT before an error response.

Ports:
- sys_clk  input  1  system clock.
- sys_reset  input  1  reset.
- req_valid  input  NUM_REQ  per-requester conversion request.
- req_channel  input  NUM_REQ  per-requester ADC channel select (bit i belongs to requester i).
- req_ready  output  NUM_REQ  request accepted this cycle.
- rsp_valid  output  NUM_REQ  one-cycle response strobe to requester i.
- rsp_data  output  DATA_W  result, shared by all requesters, valid with rsp_valid.
- rsp_error  output  1  result timed out, valid with rsp_valid.
- conv_start  output  1  one-cycle start pulse to the SPI engine.
- conv_channel  output  1  channel for the engine; held stable from the start pulse through done.
- conv_busy  input  1  engine mid-transaction.
- conv_done  input  1  one-cycle result strobe from the engine.
- conv_data  input  DATA_W  engine result, valid with conv_done.
- sched_busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: single clock, sys_clk. sys_reset is synchronous and active-high.
- Reset values: state=IDLE; all outputs 0; grant pointer = NUM_REQ-1, so requester 0 wins first; timeout counter 0.
- IDLE:
  - Winner = first i with req_valid[i], searching from pointer+1 modulo NUM_REQ.
  - req_ready[winner] is combinational, asserted only in IDLE, one-hot.
  - On handshake: latch winner id and req_channel[winner]; pointer <= winner; go to LAUNCH.
  - No requests: stay in IDLE.
- LAUNCH:
  - If conv_busy=0, pulse conv_start for one cycle, clear the timeout counter and go to WAIT.
  - Otherwise hold in LAUNCH with conv_start=0.
- WAIT:
  - Counter increments each cycle.
  - conv_done=1: latch conv_data, set error flag 0, go to RESP. conv_done wins if it coincides with timeout.
  - Counter reaches TIMEOUT_CYCLES-1 without done: set error=1, data=0, go to RESP.
- RESP:
  - rsp_valid[id]=1 for exactly one cycle; rsp_data and rsp_error are registered.
  - Next state is IDLE. A new grant is possible in the cycle after RESP.
- Latency: handshake cycle N → conv_start at N+1 if the engine is idle → response the cycle after conv_done is sampled.
- conv_done outside WAIT is ignored.
- A requester dropping req_valid before it is granted is legal; it is simply not served.
- Simultaneous requests are served in rotating order; no requester waits more than NUM_REQ-1 other grants.
- sys_reset mid-transaction: return to IDLE immediately; no response issued; a stale conv_done afterwards is ignored.
- rsp_data holds its last value between responses.

Optional Feature:
- ADC_AVG_EN defined: each accepted request performs 4 back-to-back conversions on the latched channel (LAUNCH→WAIT repeated).
  - A DATA_W+2 accumulator sums the results; rsp_data = sum>>2, truncated.
  - Any timeout aborts the remaining conversions and responds with rsp_error=1, rsp_data=0.
  - The timeout counter restarts at each conversion.
- ADC_AVG_EN undefined: single conversion per request as above; no accumulator logic.

Test Plan:
- Single request: req_valid[0]=1, channel=1; engine returns 12'hA5C 40 cycles after start.
  - Required: req_ready[0] in the same cycle; conv_start one cycle later with conv_channel=1; rsp_valid[0] with rsp_data=12'hA5C, rsp_error=0.
- Contention: both requesters held valid for 4 requests.
  - Required: grants in order 0,1,0,1; rsp_valid goes only to the granted index each time.
- Busy engine: conv_busy=1 for 10 cycles at the grant.
  - Required: conv_start is withheld until the cycle after conv_busy falls, then a single pulse.
- Timeout: engine never asserts done with TIMEOUT_CYCLES=16.
  - Required: rsp_valid with rsp_error=1, rsp_data=0, exactly 16 cycles after start; next request is served normally.
- Reset mid-WAIT, then a stale conv_done.
  - Required: all outputs 0, no rsp_valid, pointer reset so requester 0 wins next.
- ADC_AVG_EN build: conversions return 100, 101, 102, 105.
  - Required: rsp_data=102, exactly 4 conv_start pulses.
